memory_port_arbiter: RTL and testbench

MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

---
 rtl/memory_port_arbiter_if.sv | 50 +++++
 rtl/memory_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_memory_port_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_port_arbiter_if.sv
// memory_port_arbiter_if
// Bundles every handshake and memory-bus signal of the memory port arbiter.
//   master : the environment side (fetch stage, MEM stage and the memory itself)
//   slave  : the arbiter side
// Requester signals : IF_ReqValid/IF_Address, MEM_ReqValid/MEM_OpCode/MEM_Address/MEM_WriteData
// Requester returns : IF_Grant/MEM_Grant, IF_ReadData/MEM_ReadData, IF_Stall/MEM_Stall
// Memory bus        : Mem_Address, Mem_WriteData, Mem_ReadEnable, Mem_WriteEnable (to memory)
//                     Mem_ReadData, Mem_Ready (from memory)
// Status            : BusError (sticky timeout flag)
interface memory_port_arbiter_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              IF_ReqValid;
   logic [ADDR_W-1:0] IF_Address;
   logic              MEM_ReqValid;
   logic [3:0]        MEM_OpCode;
   logic [ADDR_W-1:0] MEM_Address;
   logic [DATA_W-1:0] MEM_WriteData;

   logic              IF_Grant;
   logic              MEM_Grant;
   logic [DATA_W-1:0] IF_ReadData;
   logic [DATA_W-1:0] MEM_ReadData;
   logic              IF_Stall;
   logic              MEM_Stall;

   logic [ADDR_W-1:0] Mem_Address;
   logic [DATA_W-1:0] Mem_WriteData;
   logic              Mem_ReadEnable;
   logic              Mem_WriteEnable;
   logic [DATA_W-1:0] Mem_ReadData;
   logic              Mem_Ready;

   logic              BusError;

   modport master (
      output IF_ReqValid, IF_Address, MEM_ReqValid, MEM_OpCode, MEM_Address, MEM_WriteData,
      output Mem_ReadData, Mem_Ready,
      input  IF_Grant, MEM_Grant, IF_ReadData, MEM_ReadData, IF_Stall, MEM_Stall,
      input  Mem_Address, Mem_WriteData, Mem_ReadEnable, Mem_WriteEnable, BusError
   );

   modport slave (
      input  IF_ReqValid, IF_Address, MEM_ReqValid, MEM_OpCode, MEM_Address, MEM_WriteData,
      input  Mem_ReadData, Mem_Ready,
      output IF_Grant, MEM_Grant, IF_ReadData, MEM_ReadData, IF_Stall, MEM_Stall,
      output Mem_Address, Mem_WriteData, Mem_ReadEnable, Mem_WriteEnable, BusError
   );
endinterface

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Shares one single-port memory between the instruction fetch (IF) and MEM pipeline stages.
// MEM normally wins, but after STARVE_LIMIT consecutive MEM wins over a waiting fetch the
// fetch is served. An access that sees no Mem_Ready for TIMEOUT cycles is forced to finish,
// returns 0 as read data and raises the sticky BusError flag.
// Ports:
//   ClockInput : clock, all state changes on its rising edge
//   ResetInput : asynchronous active-high reset
//   bus        : slave side of memory_port_arbiter_if (requests, grants, memory bus, BusError)
// ADDR_W/DATA_W must match the parameters of the connected interface instance.
module memory_port_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 16,
   parameter int STARVE_LIMIT = 3,
   parameter int TIMEOUT      = 15
) (
   input logic                  ClockInput,
   input logic                  ResetInput,
   memory_port_arbiter_if.slave bus
);
   localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
   localparam logic [WC_W-1:0] WAIT_LAST  = WC_W'(TIMEOUT - 1);
   localparam logic [3:0]      OP_LW      = 4'd2;
   localparam logic [3:0]      OP_SW      = 4'd3;

   typedef enum logic [1:0] {IDLE, IF_ACCESS, MEM_ACCESS} state_t;

   state_t            state;
   state_t            state_next;
   logic              mem_valid;
   logic              start_if;
   logic              start_mem;
   logic              done_ready;
   logic              done_timeout;
   logic              rd_en;
   logic              wr_en;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_data;
   logic [3:0]        lat_op;
   logic [SC_W-1:0]   starve_count;
   logic [WC_W-1:0]   wait_count;
   logic              if_grant;
   logic              mem_grant;
   logic [DATA_W-1:0] if_rdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              bus_error;

   // Only loads and stores count as MEM requests; any other opcode is invisible.
   assign mem_valid = bus.MEM_ReqValid && (bus.MEM_OpCode == OP_LW || bus.MEM_OpCode == OP_SW);

   // State register. Reset forces IDLE asynchronously so the memory enables,
   // which decode straight from the state, drop without waiting for a clock edge.
   always_ff @(posedge ClockInput or posedge ResetInput) begin
      if (ResetInput) state <= IDLE;
      else            state <= state_next;
   end

   // Next-state and memory-enable decode. In IDLE the MEM stage wins unless the
   // fetch has already lost STARVE_MAX times in a row. In an access state,
   // Mem_Ready takes priority over the timeout, so a ready arriving in the very
   // last allowed cycle still completes as a normal access.
   always_comb begin
      state_next   = state;
      start_if     = 1'b0;
      start_mem    = 1'b0;
      done_ready   = 1'b0;
      done_timeout = 1'b0;
      rd_en        = 1'b0;
      wr_en        = 1'b0;
      case (state)
         IDLE: begin
            if (mem_valid && !(bus.IF_ReqValid && starve_count == STARVE_MAX)) begin
               state_next = MEM_ACCESS;
               start_mem  = 1'b1;
            end else if (bus.IF_ReqValid) begin
               state_next = IF_ACCESS;
               start_if   = 1'b1;
            end
         end
         IF_ACCESS, MEM_ACCESS: begin
            if (state == MEM_ACCESS && lat_op == OP_SW) wr_en = 1'b1;
            else                                        rd_en = 1'b1;
            if (bus.Mem_Ready) begin
               done_ready = 1'b1;
               state_next = IDLE;
            end else if (wait_count == WAIT_LAST) begin
               done_timeout = 1'b1;
               state_next   = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Request latching, fairness and timeout counters, grant pulses and read
   // results. The requester's inputs are captured once on entry so they may
   // change freely while the access is in flight. Grants are registered, so
   // they appear in the cycle after completion, which is already an IDLE cycle.
   always_ff @(posedge ClockInput or posedge ResetInput) begin
      if (ResetInput) begin
         lat_addr     <= '0;
         lat_data     <= '0;
         lat_op       <= '0;
         starve_count <= '0;
         wait_count   <= '0;
         if_grant     <= 1'b0;
         mem_grant    <= 1'b0;
         if_rdata     <= '0;
         mem_rdata    <= '0;
         bus_error    <= 1'b0;
      end else begin
         if_grant  <= (state == IF_ACCESS)  && (done_ready || done_timeout);
         mem_grant <= (state == MEM_ACCESS) && (done_ready || done_timeout);

         if (start_if) begin
            lat_addr     <= bus.IF_Address;
            lat_op       <= 4'd0;
            wait_count   <= '0;
            starve_count <= '0;
         end else if (start_mem) begin
            lat_addr   <= bus.MEM_Address;
            lat_data   <= bus.MEM_WriteData;
            lat_op     <= bus.MEM_OpCode;
            wait_count <= '0;
            if (bus.IF_ReqValid && starve_count != STARVE_MAX)
               starve_count <= starve_count + 1'b1;
         end else if (state != IDLE && !done_ready && !done_timeout) begin
            wait_count <= wait_count + 1'b1;
         end

         if (state == IF_ACCESS) begin
            if (done_ready)        if_rdata <= bus.Mem_ReadData;
            else if (done_timeout) if_rdata <= '0;
         end
         if (state == MEM_ACCESS && lat_op == OP_LW) begin
            if (done_ready)        mem_rdata <= bus.Mem_ReadData;
            else if (done_timeout) mem_rdata <= '0;
         end

         if (done_timeout) bus_error <= 1'b1;
      end
   end

   assign bus.Mem_Address     = lat_addr;
   assign bus.Mem_WriteData   = lat_data;
   assign bus.Mem_ReadEnable  = rd_en;
   assign bus.Mem_WriteEnable = wr_en;
   assign bus.IF_Grant        = if_grant;
   assign bus.MEM_Grant       = mem_grant;
   assign bus.IF_ReadData     = if_rdata;
   assign bus.MEM_ReadData    = mem_rdata;
   assign bus.BusError        = bus_error;

   // Stalls are combinational so a requester is released in its grant cycle.
   assign bus.IF_Stall  = bus.IF_ReqValid & ~if_grant;
   assign bus.MEM_Stall = mem_valid & ~mem_grant;
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter
// Drives the arbiter through fetch reads, stores, starvation, timeout, mid-access
// reset and non-access opcodes. Each request pushes its expected grant (which port,
// and the read data that port must then hold) onto a scoreboard; a monitor pops and
// compares whenever a grant pulse is seen. Memory contents come from a bench array.
module tb_memory_port_arbiter;
   localparam int ADDR_W       = 8;
   localparam int DATA_W       = 16;
   localparam int STARVE_LIMIT = 3;
   localparam int TIMEOUT      = 15;

   logic ClockInput = 1'b0;
   logic ResetInput = 1'b1;

   memory_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   memory_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
   ) dut (
      .ClockInput(ClockInput),
      .ResetInput(ResetInput),
      .bus(bus)
   );

   always #5 ClockInput = ~ClockInput;

   typedef struct packed {
      logic              is_if;
      logic [DATA_W-1:0] data;
   } expect_t;

   expect_t           scoreboard[$];
   expect_t           mon_exp;
   logic [DATA_W-1:0] mon_data;
   logic [DATA_W-1:0] mem_array [256];
   int                checks = 0;
   int                fails  = 0;

   // Simple memory model: read data follows the address the arbiter presents.
   always_comb bus.Mem_ReadData = mem_array[bus.Mem_Address];

   // Scoreboard monitor: every grant pulse must match the oldest expectation.
   always @(negedge ClockInput) begin
      if (!ResetInput && (bus.IF_Grant || bus.MEM_Grant)) begin
         checks++;
         if (scoreboard.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_grant: IF_Grant=%0b MEM_Grant=%0b, required no grant",
                     bus.IF_Grant, bus.MEM_Grant);
         end else begin
            mon_exp  = scoreboard.pop_front();
            mon_data = bus.IF_Grant ? bus.IF_ReadData : bus.MEM_ReadData;
            if (bus.IF_Grant !== mon_exp.is_if || bus.MEM_Grant !== ~mon_exp.is_if ||
                mon_data !== mon_exp.data) begin
               fails++;
               $display("[TB] FAIL grant_order_data: IF_Grant=%0b MEM_Grant=%0b data=%h, required IF=%0b data=%h",
                        bus.IF_Grant, bus.MEM_Grant, mon_data, mon_exp.is_if, mon_exp.data);
            end
         end
      end
   end

   // Steps negedges until a grant is visible; cycles=-1 when the budget runs out.
   task automatic run_until_grant(input int budget, output int cycles);
      cycles = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge ClockInput);
         if (bus.IF_Grant || bus.MEM_Grant) begin
            cycles = i;
            break;
         end
      end
   endtask

   task automatic drop_requests();
      bus.IF_ReqValid  = 1'b0;
      bus.MEM_ReqValid = 1'b0;
      bus.MEM_OpCode   = 4'd0;
      bus.Mem_Ready    = 1'b0;
   endtask

   task automatic test_reset();
      ResetInput = 1'b1;
      @(negedge ClockInput);
      bus.IF_ReqValid  = 1'b1;
      bus.MEM_ReqValid = 1'b1;
      bus.MEM_OpCode   = 4'd2;
      bus.Mem_Ready    = 1'b1;
      @(negedge ClockInput);
      checks++;
      if (bus.Mem_ReadEnable !== 1'b0 || bus.Mem_WriteEnable !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_enables: read=%0b write=%0b, required 0/0",
                  bus.Mem_ReadEnable, bus.Mem_WriteEnable);
      end
      checks++;
      if (bus.IF_Grant !== 1'b0 || bus.MEM_Grant !== 1'b0 || bus.BusError !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_flags: IF_Grant=%0b MEM_Grant=%0b BusError=%0b, required 0",
                  bus.IF_Grant, bus.MEM_Grant, bus.BusError);
      end
      checks++;
      if (bus.IF_ReadData !== '0 || bus.MEM_ReadData !== '0 || bus.Mem_Address !== '0) begin
         fails++;
         $display("[TB] FAIL reset_data: IF=%h MEM=%h addr=%h, required 0",
                  bus.IF_ReadData, bus.MEM_ReadData, bus.Mem_Address);
      end
      checks++;
      if (bus.IF_Stall !== 1'b1 || bus.MEM_Stall !== 1'b1) begin
         fails++;
         $display("[TB] FAIL reset_stalls: IF_Stall=%0b MEM_Stall=%0b, required 1/1",
                  bus.IF_Stall, bus.MEM_Stall);
      end
      drop_requests();
      ResetInput = 1'b0;
      @(negedge ClockInput);
   endtask

   task automatic test_if_read();
      scoreboard.push_back('{is_if: 1'b1, data: mem_array[8'h10]});
      @(negedge ClockInput);
      bus.IF_ReqValid = 1'b1;
      bus.IF_Address  = 8'h10;
      #1;
      checks++;
      if (bus.IF_Stall !== 1'b1 || bus.Mem_ReadEnable !== 1'b0) begin
         fails++;
         $display("[TB] FAIL if_request_idle: IF_Stall=%0b read=%0b, required 1/0",
                  bus.IF_Stall, bus.Mem_ReadEnable);
      end
      @(negedge ClockInput);
      checks++;
      if (bus.Mem_ReadEnable !== 1'b1 || bus.Mem_WriteEnable !== 1'b0 || bus.Mem_Address !== 8'h10) begin
         fails++;
         $display("[TB] FAIL if_access_bus: read=%0b write=%0b addr=%h, required 1/0/10",
                  bus.Mem_ReadEnable, bus.Mem_WriteEnable, bus.Mem_Address);
      end
      bus.IF_Address = 8'h77;
      bus.Mem_Ready  = 1'b1;
      @(negedge ClockInput);
      checks++;
      if (bus.IF_Grant !== 1'b1 || bus.Mem_ReadEnable !== 1'b0 || bus.IF_Stall !== 1'b0) begin
         fails++;
         $display("[TB] FAIL if_grant_cycle: grant=%0b read=%0b stall=%0b, required 1/0/0",
                  bus.IF_Grant, bus.Mem_ReadEnable, bus.IF_Stall);
      end
      drop_requests();
      @(negedge ClockInput);
      checks++;
      if (bus.IF_Grant !== 1'b0 || bus.IF_ReadData !== 16'hBEEF || bus.Mem_ReadEnable !== 1'b0) begin
         fails++;
         $display("[TB] FAIL if_after_grant: grant=%0b data=%h read=%0b, required 0/beef/0",
                  bus.IF_Grant, bus.IF_ReadData, bus.Mem_ReadEnable);
      end
   endtask

   task automatic test_sw_write();
      logic [DATA_W-1:0] prev_mem_rd = '0;
      scoreboard.push_back('{is_if: 1'b0, data: prev_mem_rd});
      @(negedge ClockInput);
      bus.MEM_ReqValid  = 1'b1;
      bus.MEM_OpCode    = 4'd3;
      bus.MEM_Address   = 8'h20;
      bus.MEM_WriteData = 16'h1234;
      #1;
      checks++;
      if (bus.MEM_Stall !== 1'b1 || bus.Mem_WriteEnable !== 1'b0) begin
         fails++;
         $display("[TB] FAIL sw_request_idle: stall=%0b write=%0b, required 1/0",
                  bus.MEM_Stall, bus.Mem_WriteEnable);
      end
      for (int k = 1; k <= 3; k++) begin
         @(negedge ClockInput);
         if (k == 1) bus.MEM_WriteData = 16'hFFFF;
         checks++;
         if (bus.Mem_WriteEnable !== 1'b1 || bus.Mem_ReadEnable !== 1'b0 ||
             bus.Mem_WriteData !== 16'h1234 || bus.Mem_Address !== 8'h20 || bus.MEM_Stall !== 1'b1) begin
            fails++;
            $display("[TB] FAIL sw_access_cycle%0d: write=%0b read=%0b wdata=%h addr=%h stall=%0b, required 1/0/1234/20/1",
                     k, bus.Mem_WriteEnable, bus.Mem_ReadEnable, bus.Mem_WriteData,
                     bus.Mem_Address, bus.MEM_Stall);
         end
         if (k == 3) bus.Mem_Ready = 1'b1;
      end
      @(negedge ClockInput);
      checks++;
      if (bus.MEM_Grant !== 1'b1 || bus.Mem_WriteEnable !== 1'b0 || bus.MEM_Stall !== 1'b0) begin
         fails++;
         $display("[TB] FAIL sw_grant_cycle: grant=%0b write=%0b stall=%0b, required 1/0/0",
                  bus.MEM_Grant, bus.Mem_WriteEnable, bus.MEM_Stall);
      end
      drop_requests();
      @(negedge ClockInput);
      checks++;
      if (bus.MEM_Grant !== 1'b0 || bus.MEM_Stall !== 1'b0 || bus.MEM_ReadData !== prev_mem_rd) begin
         fails++;
         $display("[TB] FAIL sw_after_grant: grant=%0b stall=%0b rdata=%h, required 0/0/%h",
                  bus.MEM_Grant, bus.MEM_Stall, bus.MEM_ReadData, prev_mem_rd);
      end
   endtask

   task automatic test_starvation();
      int seen = 0;
      for (int g = 0; g < 5; g++) begin
         if (g == 3) scoreboard.push_back('{is_if: 1'b1, data: mem_array[8'h30]});
         else        scoreboard.push_back('{is_if: 1'b0, data: mem_array[8'h40]});
      end
      @(negedge ClockInput);
      bus.IF_ReqValid  = 1'b1;
      bus.IF_Address   = 8'h30;
      bus.MEM_ReqValid = 1'b1;
      bus.MEM_OpCode   = 4'd2;
      bus.MEM_Address  = 8'h40;
      bus.Mem_Ready    = 1'b1;
      for (int i = 0; i < 30 && seen < 5; i++) begin
         @(negedge ClockInput);
         if (bus.IF_Grant || bus.MEM_Grant) seen++;
      end
      drop_requests();
      checks++;
      if (seen !== 5) begin
         fails++;
         $display("[TB] FAIL starvation_grant_count: got %0d grants, required 5", seen);
      end
      @(negedge ClockInput);
   endtask

   task automatic test_timeout();
      int active = 0;
      int cycles;
      logic got_grant = 1'b0;
      scoreboard.push_back('{is_if: 1'b0, data: mem_array[8'h60]});
      @(negedge ClockInput);
      bus.MEM_ReqValid = 1'b1;
      bus.MEM_OpCode   = 4'd2;
      bus.MEM_Address  = 8'h60;
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(negedge ClockInput);
         if (k == TIMEOUT) bus.Mem_Ready = 1'b1;
      end
      @(negedge ClockInput);
      checks++;
      if (bus.MEM_Grant !== 1'b1 || bus.BusError !== 1'b0) begin
         fails++;
         $display("[TB] FAIL ready_in_last_cycle: grant=%0b BusError=%0b, required 1/0",
                  bus.MEM_Grant, bus.BusError);
      end
      drop_requests();

      scoreboard.push_back('{is_if: 1'b0, data: '0});
      @(negedge ClockInput);
      bus.MEM_ReqValid = 1'b1;
      bus.MEM_OpCode   = 4'd2;
      bus.MEM_Address  = 8'h50;
      for (int i = 0; i < 40; i++) begin
         @(negedge ClockInput);
         if (bus.MEM_Grant) begin
            got_grant = 1'b1;
            break;
         end
         if (bus.Mem_ReadEnable) active++;
      end
      checks++;
      if (got_grant !== 1'b1 || active != TIMEOUT || bus.BusError !== 1'b1) begin
         fails++;
         $display("[TB] FAIL timeout_access: grant=%0b access_cycles=%0d BusError=%0b, required 1/%0d/1",
                  got_grant, active, bus.BusError, TIMEOUT);
      end
      drop_requests();
      @(negedge ClockInput);

      scoreboard.push_back('{is_if: 1'b1, data: mem_array[8'h10]});
      bus.IF_ReqValid = 1'b1;
      bus.IF_Address  = 8'h10;
      bus.Mem_Ready   = 1'b1;
      run_until_grant(10, cycles);
      checks++;
      if (cycles != 2 || bus.BusError !== 1'b1) begin
         fails++;
         $display("[TB] FAIL if_after_timeout: latency=%0d BusError=%0b, required 2/1",
                  cycles, bus.BusError);
      end
      drop_requests();
      @(negedge ClockInput);
   endtask

   task automatic test_reset_mid_access();
      int cycles;
      scoreboard.push_back('{is_if: 1'b0, data: mem_array[8'h40]});
      @(negedge ClockInput);
      bus.MEM_ReqValid = 1'b1;
      bus.MEM_OpCode   = 4'd2;
      bus.MEM_Address  = 8'h40;
      @(negedge ClockInput);
      checks++;
      if (bus.Mem_ReadEnable !== 1'b1) begin
         fails++;
         $display("[TB] FAIL mid_reset_precondition: read=%0b, required 1", bus.Mem_ReadEnable);
      end
      #2;
      ResetInput = 1'b1;
      #1;
      checks++;
      if (bus.Mem_ReadEnable !== 1'b0 || bus.Mem_WriteEnable !== 1'b0 ||
          bus.MEM_Grant !== 1'b0 || bus.MEM_Stall !== 1'b1) begin
         fails++;
         $display("[TB] FAIL mid_reset_async: read=%0b write=%0b grant=%0b stall=%0b, required 0/0/0/1",
                  bus.Mem_ReadEnable, bus.Mem_WriteEnable, bus.MEM_Grant, bus.MEM_Stall);
      end
      @(negedge ClockInput);
      @(negedge ClockInput);
      checks++;
      if (bus.MEM_Grant !== 1'b0 || bus.BusError !== 1'b0) begin
         fails++;
         $display("[TB] FAIL mid_reset_held: grant=%0b BusError=%0b, required 0/0",
                  bus.MEM_Grant, bus.BusError);
      end
      ResetInput    = 1'b0;
      bus.Mem_Ready = 1'b1;
      run_until_grant(10, cycles);
      checks++;
      if (cycles != 2 || bus.MEM_Grant !== 1'b1) begin
         fails++;
         $display("[TB] FAIL mid_reset_rearbitrate: latency=%0d grant=%0b, required 2/1",
                  cycles, bus.MEM_Grant);
      end
      drop_requests();
      @(negedge ClockInput);
   endtask

   task automatic test_invalid_opcode();
      bus.Mem_Ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.MEM_ReqValid = 1'b1;
         bus.MEM_OpCode   = (k % 2 == 0) ? 4'd1 : 4'hA;
         bus.MEM_Address  = 8'h40;
         @(negedge ClockInput);
         checks++;
         if (bus.MEM_Stall !== 1'b0 || bus.MEM_Grant !== 1'b0 ||
             bus.Mem_ReadEnable !== 1'b0 || bus.Mem_WriteEnable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL invalid_opcode%0d: stall=%0b grant=%0b read=%0b write=%0b, required 0/0/0/0",
                     k, bus.MEM_Stall, bus.MEM_Grant, bus.Mem_ReadEnable, bus.Mem_WriteEnable);
         end
      end
      drop_requests();
      @(negedge ClockInput);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_array[i] = {8'(i), ~8'(i)};
      mem_array[8'h10] = 16'hBEEF;
      mem_array[8'h20] = 16'hDEAD;
      mem_array[8'h30] = 16'h3030;
      mem_array[8'h40] = 16'h4040;
      mem_array[8'h50] = 16'h5555;
      mem_array[8'h60] = 16'h6066;
      bus.IF_ReqValid   = 1'b0;
      bus.IF_Address    = '0;
      bus.MEM_ReqValid  = 1'b0;
      bus.MEM_OpCode    = 4'd0;
      bus.MEM_Address   = '0;
      bus.MEM_WriteData = '0;
      bus.Mem_Ready     = 1'b0;

      test_reset();
      test_if_read();
      test_sw_write();
      test_starvation();
      test_timeout();
      test_reset_mid_access();
      test_invalid_opcode();

      checks++;
      if (scoreboard.size() != 0) begin
         fails++;
         $display("[TB] FAIL scoreboard_drained: %0d grants outstanding, required 0", scoreboard.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
